// File: rtl/reg_serial_reader.sv
// MSB-first serial transmitter for a captured parallel word, with valid/last/done framing.
// Optional PARITY_EN macro appends an even-parity bit as the final frame bit.
module reg_serial_reader #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_hold,
    output logic             o_ready,
    output logic             o_serial_out,
    output logic             o_serial_valid,
    output logic             o_last,
    output logic             o_done
);

`ifdef PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StPar, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
`endif

    state_e             r_state, w_state_d;
    logic [WIDTH-1:0]   r_shift, w_shift_d;
    logic [CNT_W-1:0]   r_cnt, w_cnt_d;
`ifdef PARITY_EN
    logic               r_parity, w_parity_d;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_shift  <= '0;
            r_cnt    <= '0;
`ifdef PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_d;
            r_shift  <= w_shift_d;
            r_cnt    <= w_cnt_d;
`ifdef PARITY_EN
            r_parity <= w_parity_d;
`endif
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_shift_d  = r_shift;
        w_cnt_d    = r_cnt;
`ifdef PARITY_EN
        w_parity_d = r_parity;
`endif
        case (r_state)
            StIdle: begin
                if (i_enable) begin
                    w_shift_d  = i_d;
                    w_cnt_d    = CNT_W'(WIDTH - 1);
`ifdef PARITY_EN
                    w_parity_d = ^i_d;
`endif
                    w_state_d  = StShift;
                end
            end
            StShift: begin
                if (!i_hold) begin
                    w_shift_d = {r_shift[WIDTH-2:0], 1'b0};
                    if (r_cnt == '0) begin
`ifdef PARITY_EN
                        w_state_d = StPar;
`else
                        w_state_d = StDone;
`endif
                    end else begin
                        w_cnt_d = r_cnt - CNT_W'(1);
                    end
                end
            end
`ifdef PARITY_EN
            StPar: begin
                if (!i_hold) begin
                    w_state_d = StDone;
                end
            end
`endif
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs decode only registered state, so no input reaches an output combinationally.
    always_comb begin
        o_ready        = 1'b0;
        o_serial_out   = 1'b0;
        o_serial_valid = 1'b0;
        o_last         = 1'b0;
        o_done         = 1'b0;
        case (r_state)
            StIdle: o_ready = 1'b1;
            StShift: begin
                o_serial_out   = r_shift[WIDTH-1];
                o_serial_valid = 1'b1;
`ifndef PARITY_EN
                o_last         = (r_cnt == '0);
`endif
            end
`ifdef PARITY_EN
            StPar: begin
                o_serial_out   = r_parity;
                o_serial_valid = 1'b1;
                o_last         = 1'b1;
            end
`endif
            StDone:  o_done = 1'b1;
            default: o_ready = 1'b0;
        endcase
    end

endmodule

// File: doc/reg_serial_reader.md
Name: reg_serial_reader

Overview:
Read-side companion to the 32-bit storage register. It captures a parallel word (typically a register's Q output) on a load strobe and transmits it MSB-first, one bit per clock, with a valid/last/done indication. Downstream logic can stall it. It is the serial transmitter that pairs with the parallel-load register path for status/debug readout.

Parameters:
WIDTH, 32, data word width in bits (must be >= 2).
CNT_W, 6, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  reset; synchronous, active-low.
enable  input  1  load request; sampled only when ready=1.
D  input  WIDTH  parallel word to transmit.
hold  input  1  stall; freezes the shift/count state while in SHIFT.
ready  output  1  block is idle and will accept a load.
serial_out  output  1  current serial bit, MSB first.
serial_valid  output  1  serial_out carries a valid bit this cycle.
last  output  1  current bit is the final bit of the frame.
done  output  1  one-cycle pulse after the frame completes.

Behaviour:
- Reset is synchronous and active-low: rst_n=0 at a rising clk edge forces state IDLE, shift register=0, counter=0, serial_out=0, serial_valid=0, last=0, done=0. From the next cycle, ready=1.
- Reset applied mid-frame aborts the frame. No done pulse is produced. The partial frame is discarded.
- States are IDLE, SHIFT, (PAR when PARITY_EN), and DONE.
- IDLE: ready=1 and serial_valid=0. On an edge with enable=1, the block captures D into the shift register, sets counter=WIDTH-1, and goes to SHIFT. D is ignored at all other times.
- SHIFT: ready=0 and serial_valid=1. serial_out is the shift-register MSB. last=1 when counter==0 (and parity is disabled).
  - On an edge with hold=0: shift left by one and fill with 0. If counter==0, go to the next state; otherwise decrement the counter.
  - On an edge with hold=1: shift register, counter, and outputs are unchanged. The same bit stays presented.
- Latency: if the load is accepted at edge N, bit WIDTH-1-k is presented during cycle N+1+k (no holds). The last data bit is presented in cycle N+WIDTH.
- DONE: lasts exactly one cycle with done=1, serial_valid=0, ready=0. It then returns to IDLE, so the earliest next load is 2 cycles after the last bit.
- enable asserted while ready=0 is ignored. The request is not queued.
- hold has no effect in IDLE or DONE.
- All outputs are registered or decoded purely from state. There is no combinational path from any input to any output.

Optional Feature:
PARITY_EN.
- Defined: an even-parity bit (XOR of all captured WIDTH bits) is computed at load time. It is sent in state PAR for one cycle after the last data bit, with serial_valid=1 and last=1 on the parity bit (not on the final data bit). PAR honours hold. The frame is WIDTH+1 bits, and done is pulsed after PAR.
- Undefined: there is no PAR state, frames are WIDTH bits, and last marks data bit 0.

Test Plan:
1. Load 0xFFFFFFFF with enable=1 in IDLE.
   - Expected: ready=0 from the next cycle, serial_out=1 for 32 consecutive cycles with serial_valid=1, last=1 only in the 32nd cycle.
   - Then done=1 for one cycle, then ready=1.
   - With PARITY_EN: 33rd bit = 0.
2. Load 0x80000801.
   - Expected serial stream: 1, 19 zeros, 1, 10 zeros, 1.
   - With PARITY_EN: parity bit = 1.
3. Load 0xAAAAAAAA, then assert hold for 3 cycles while bit 28 is presented.
   - Expected: serial_out stays 0 and serial_valid stays 1 for 4 cycles total.
   - The stream then resumes 1,0,… and done arrives 3 cycles later than in the unstalled case.
4. During a frame of 0x12345678, pulse enable with D=0xDEADBEEF.
   - Expected: the request is ignored and the full 0x12345678 stream completes unchanged.
5. Drop rst_n for one edge after 10 bits of 0x55555555.
   - Expected next cycle: serial_valid=0, done=0, ready=1, no done pulse.
   - A new load of 0x00000001 then yields 31 zeros followed by 1.
6. Issue two back-to-back loads, each asserted at the first cycle ready=1.
   - Expected: 32 data cycles, 1 done cycle, 1 idle cycle between frames (gap of 2 cycles between the last bit and the next first bit).
